glb_bank_req_arbiter: RTL

//  Front end of one GLB bank; drives the bank memory's ren/wen/addr/data_in/data_in_bit_sel.

---
 rtl/glb_bank_req_arbiter_pkg.sv | 28 ++
 rtl/glb_bank_req_arbiter_shift_pipe.sv | 43 ++++
 rtl/glb_bank_req_arbiter.sv | 85 ++++++++
 3 files changed

// File: rtl/glb_bank_req_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | global_buffer_param : shared GLB bank geometry and helper functions   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package global_buffer_param;

  localparam int BANK_DATA_WIDTH     = 64;
  localparam int BANK_ADDR_WIDTH     = 17;
  localparam int BANK_BYTE_OFFSET    = 3;
  localparam int BANK_STRB_WIDTH     = BANK_DATA_WIDTH / 8;
  localparam int GLB_BANK_RD_LATENCY = 3;

  function automatic logic [BANK_DATA_WIDTH-1:0] expand_strb(
    input logic [BANK_STRB_WIDTH-1:0] strb
  );
    logic [BANK_DATA_WIDTH-1:0] bits;
    bits = '0;
    for (int i = 0; i < BANK_STRB_WIDTH; i++) begin
      bits[8*i +: 8] = {8{strb[i]}};
    end
    return bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/glb_bank_req_arbiter_shift_pipe.sv
// +----------------------------------------------------------------------+
// | glb_shift_pipe : sync-reset valid + payload delay line of DEPTH      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module glb_shift_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_valid[0] <= in_valid;
      r_data[0]  <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/glb_bank_req_arbiter.sv
// +----------------------------------------------------------------------+
// | glb_bank_req_arbiter : write/read issue arbiter for one GLB bank with |
// | starvation bound and latency-aligned tagged read response            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module glb_bank_req_arbiter
  import global_buffer_param::*;
#(
  parameter int TAG_WIDTH  = 4,
  parameter int STARVE_MAX = 4,
  parameter int RD_LATENCY = GLB_BANK_RD_LATENCY
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [BANK_ADDR_WIDTH-1:0] wr_addr,
  input  logic [BANK_DATA_WIDTH-1:0] wr_data,
  input  logic [BANK_STRB_WIDTH-1:0] wr_strb,
  input  logic                       rd_valid,
  output logic                       rd_ready,
  input  logic [BANK_ADDR_WIDTH-1:0] rd_addr,
  input  logic [TAG_WIDTH-1:0]       rd_tag,
  output logic                       rd_resp_valid,
  output logic [TAG_WIDTH-1:0]       rd_resp_tag,
  output logic [BANK_DATA_WIDTH-1:0] rd_resp_data,
  output logic                       mem_ren,
  output logic                       mem_wen,
  output logic [BANK_ADDR_WIDTH-1:0] mem_addr,
  output logic [BANK_DATA_WIDTH-1:0] mem_data_in,
  output logic [BANK_DATA_WIDTH-1:0] mem_bit_sel,
  input  logic [BANK_DATA_WIDTH-1:0] mem_data_out
);

  localparam int c_cnt_w = $clog2(STARVE_MAX + 1);

  logic [c_cnt_w-1:0] r_starve_cnt;
  logic               w_force_rd;
  logic               w_grant_wr;
  logic               w_grant_rd;

  // Grants are masked by reset so nothing reaches the SRAM while in reset.
  assign w_force_rd = (r_starve_cnt == c_cnt_w'(STARVE_MAX));
  assign w_grant_wr = wr_valid & ~w_force_rd & ~reset;
  assign w_grant_rd = rd_valid & ~w_grant_wr & ~reset;

  assign wr_ready = w_grant_wr;
  assign rd_ready = w_grant_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_grant_rd || !rd_valid) begin
      r_starve_cnt <= '0;
    end else if (!w_force_rd) begin
      r_starve_cnt <= r_starve_cnt + c_cnt_w'(1);
    end
  end

  assign mem_wen     = w_grant_wr;
  assign mem_ren     = w_grant_rd;
  assign mem_addr    = w_grant_wr ? wr_addr : rd_addr;
  assign mem_data_in = w_grant_wr ? wr_data : '0;
  assign mem_bit_sel = w_grant_wr ? expand_strb(wr_strb) : '0;

  // Tag rides alongside the SRAM read latency; data is taken straight from the SRAM.
  glb_shift_pipe #(
    .WIDTH (TAG_WIDTH),
    .DEPTH (RD_LATENCY)
  ) u_resp_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (w_grant_rd),
    .in_data   (rd_tag),
    .out_valid (rd_resp_valid),
    .out_data  (rd_resp_tag)
  );

  assign rd_resp_data = mem_data_out;

endmodule

`default_nettype wire
